// File: rtl/base_prisplit_way.sv
// rtl/base_prisplit_way.sv - one-entry valid/ready holding register for a single output way
module base_prisplit_way #(
    parameter int width = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [width-1:0] d_i,
    input  logic             rdy_i,
    output logic             full_o,
    output logic [width-1:0] data_o
);

    logic             full_q, full_d;
    logic [width-1:0] data_q, data_d;

    // Load wins over drain so a beat arriving while the old one leaves keeps the way busy.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load_i) begin
            full_d = 1'b1;
            data_d = d_i;
        end else if (full_q && rdy_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/base_prisplit.sv
// rtl/base_prisplit.sv - registered one-to-many steering of a tagged stream onto per-way outputs
module base_prisplit #(
    parameter  int ways  = 2,
    parameter  int width = 64,
    localparam int idw   = $clog2(ways)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_v,
    output logic                   i_r,
    input  logic [width-1:0]       i_d,
    input  logic [idw-1:0]         i_dst,
    output logic [ways-1:0]        o_v,
    input  logic [ways-1:0]        o_r,
    output logic [ways*width-1:0]  o_d,
    output logic                   o_err,
    output logic [15:0]            o_drop_cnt
);

    localparam int cnt_w = 16;
    localparam int pad_w = 1 << idw;

    logic [pad_w-1:0] full_pad, rdy_pad;
    logic             in_range, accept, drop;
    logic             err_q, err_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;

    // Pad to the full index range so an out-of-range i_dst never selects past the vector.
    always_comb begin
        full_pad = '0;
        rdy_pad  = '0;
        full_pad[ways-1:0] = o_v;
        rdy_pad[ways-1:0]  = o_r;
    end

    assign in_range = ({1'b0, i_dst} < (idw+1)'(ways));
    assign i_r      = reset_n & (~in_range | ~full_pad[i_dst] | rdy_pad[i_dst]);
    assign accept   = i_v & i_r;
    assign drop     = accept & ~in_range;

    for (genvar k = 0; k < ways; k++) begin : g_way
        base_prisplit_way #(.width(width)) u_way (
            .clk     (clk),
            .reset_n (reset_n),
            .load_i  (accept & in_range & (i_dst == idw'(k))),
            .d_i     (i_d),
            .rdy_i   (o_r[k]),
            .full_o  (o_v[k]),
            .data_o  (o_d[(ways-k)*width-1 -: width])
        );
    end

    always_comb begin
        err_d = drop;
        cnt_d = cnt_q;
        if (drop && (cnt_q != {cnt_w{1'b1}})) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_err      = err_q;
    assign o_drop_cnt = cnt_q;

endmodule

// File: tb/tb_base_prisplit.sv
// tb/tb_base_prisplit.sv - table-driven and sequence checks of base_prisplit (ways=4 and ways=3)
module tb_base_prisplit;

    logic        clk;
    logic        reset_n;

    logic        i_v4, i_r4;
    logic [7:0]  i_d4;
    logic [1:0]  i_dst4;
    logic [3:0]  o_v4, o_r4;
    logic [31:0] o_d4;
    logic        o_err4;
    logic [15:0] o_cnt4;

    logic        i_v3, i_r3;
    logic [7:0]  i_d3;
    logic [1:0]  i_dst3;
    logic [2:0]  o_v3, o_r3;
    logic [23:0] o_d3;
    logic        o_err3;
    logic [15:0] o_cnt3;

    int checks = 0;
    int errors = 0;

    base_prisplit #(.ways(4), .width(8)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .i_v(i_v4), .i_r(i_r4), .i_d(i_d4), .i_dst(i_dst4),
        .o_v(o_v4), .o_r(o_r4), .o_d(o_d4),
        .o_err(o_err4), .o_drop_cnt(o_cnt4)
    );

    base_prisplit #(.ways(3), .width(8)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .i_v(i_v3), .i_r(i_r3), .i_d(i_d3), .i_dst(i_dst3),
        .o_v(o_v3), .o_r(o_r3), .o_d(o_d3),
        .o_err(o_err3), .o_drop_cnt(o_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] dst;
        logic [7:0] d;
        logic [3:0] ordy;
        logic       exp_ir;
        logic [3:0] exp_ov;
        logic [31:0] exp_od;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // o_d slices: way0 [31:24], way1 [23:16], way2 [15:8], way3 [7:0]
        vecs[0] = '{1'b1, 2'd2, 8'hA5, 4'b1111, 1'b1, 4'b0100, 32'h0000A500};
        vecs[1] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h0000A500};
        vecs[2] = '{1'b1, 2'd0, 8'h11, 4'b0000, 1'b1, 4'b0001, 32'h1100A500};
        vecs[3] = '{1'b1, 2'd0, 8'h22, 4'b0000, 1'b0, 4'b0001, 32'h1100A500};
        vecs[4] = '{1'b1, 2'd3, 8'h33, 4'b0000, 1'b1, 4'b1001, 32'h1100A533};
        vecs[5] = '{1'b1, 2'd0, 8'h44, 4'b0001, 1'b1, 4'b1001, 32'h4400A533};
        vecs[6] = '{1'b1, 2'd3, 8'h55, 4'b1001, 1'b1, 4'b1000, 32'h4400A555};
        vecs[7] = '{1'b0, 2'd1, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h4400A555};

        reset_n = 1'b0;
        i_v4 = 1'b1; i_d4 = 8'h5A; i_dst4 = 2'd1; o_r4 = 4'b0000;
        i_v3 = 1'b0; i_d3 = 8'h00; i_dst3 = 2'd0; o_r3 = 3'b000;

        // Reset hold with a valid beat presented
        step();
        step();
        chk("reset_i_r", {31'd0, i_r4}, 32'd0);
        chk("reset_o_v", {28'd0, o_v4}, 32'd0);
        chk("reset_o_d", o_d4, 32'd0);
        chk("reset_cnt", {16'd0, o_cnt4}, 32'd0);
        chk("reset_err", {31'd0, o_err4}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("post_reset_i_r", {31'd0, i_r4}, 32'd1);
        step();
        chk("post_reset_o_v", {28'd0, o_v4}, 32'b0010);
        chk("post_reset_o_d", o_d4, 32'h005A0000);
        i_v4 = 1'b0; o_r4 = 4'b1111;
        step();
        chk("post_reset_drain", {28'd0, o_v4}, 32'd0);

        // Streaming: 8 back-to-back beats to way 1
        for (int i = 0; i < 8; i++) begin
            i_v4 = 1'b1; i_dst4 = 2'd1; i_d4 = 8'h10 + 8'(i); o_r4 = 4'b1111;
            #1;
            chk($sformatf("stream_i_r_%0d", i), {31'd0, i_r4}, 32'd1);
            step();
            chk($sformatf("stream_o_v_%0d", i), {28'd0, o_v4}, 32'b0010);
            chk($sformatf("stream_o_d_%0d", i), {24'd0, o_d4[23:16]}, {24'd0, 8'h10 + 8'(i)});
        end
        i_v4 = 1'b0;
        step();
        chk("stream_end_o_v", {28'd0, o_v4}, 32'd0);

        // Clear held data so the table starts from all-zero slices
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            i_v4 = vecs[i].v; i_dst4 = vecs[i].dst; i_d4 = vecs[i].d; o_r4 = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_i_r", i), {31'd0, i_r4}, {31'd0, vecs[i].exp_ir});
            step();
            chk($sformatf("vec%0d_o_v", i), {28'd0, o_v4}, {28'd0, vecs[i].exp_ov});
            chk($sformatf("vec%0d_o_d", i), o_d4, vecs[i].exp_od);
        end
        chk("vec_no_err", {31'd0, o_err4}, 32'd0);

        // Drop path on the 3-way instance
        i_v3 = 1'b1; i_dst3 = 2'd3; i_d3 = 8'hEE; o_r3 = 3'b000;
        #1;
        chk("drop_i_r", {31'd0, i_r3}, 32'd1);
        step();
        chk("drop_o_v", {29'd0, o_v3}, 32'd0);
        chk("drop_err", {31'd0, o_err3}, 32'd1);
        chk("drop_cnt", {16'd0, o_cnt3}, 32'd1);
        i_v3 = 1'b0;
        step();
        chk("drop_err_pulse", {31'd0, o_err3}, 32'd0);
        chk("drop_cnt_hold", {16'd0, o_cnt3}, 32'd1);

        force u_dut3.cnt_q = 16'hFFFE;
        #1;
        release u_dut3.cnt_q;
        #1;
        chk("sat_preload", {16'd0, o_cnt3}, 32'h0000FFFE);
        i_v3 = 1'b1; i_dst3 = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("sat_cnt_%0d", i), {16'd0, o_cnt3}, 32'h0000FFFF);
            chk($sformatf("sat_err_%0d", i), {31'd0, o_err3}, 32'd1);
        end
        i_v3 = 1'b0;
        step();
        chk("sat_final", {16'd0, o_cnt3}, 32'h0000FFFF);

        // Mid-stream asynchronous reset with ways 0 and 2 held
        o_r4 = 4'b0000;
        i_v4 = 1'b1; i_dst4 = 2'd0; i_d4 = 8'hAA;
        step();
        i_dst4 = 2'd2; i_d4 = 8'hBB;
        step();
        i_v4 = 1'b0;
        chk("mid_full", {28'd0, o_v4}, 32'b0101);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_async_o_v", {28'd0, o_v4}, 32'd0);
        chk("mid_async_i_r", {31'd0, i_r4}, 32'd0);
        chk("mid_async_cnt3", {16'd0, o_cnt3}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("mid_after_o_v", {28'd0, o_v4}, 32'd0);
        chk("mid_after_o_d", o_d4, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
